regfile_wb_sched: RTL and testbench
===================================

// Module: regfile_wb_sched
// PURPOSE
//  Writeback scheduler and scoreboard for the 32x32 register file. Shares the register
//  file's single write port between two writeback sources: the ALU and the multi-cycle
//  load unit (MEM), using round-robin arbitration. Tracks each register with a pending
//  write in a busy scoreboard. Stalls decode on RAW and WAW hazards.
// PARAMETERS
//  DATA_W  32  width of write data / rf_wd
//  ADDR_W  5   register address width; NREG = 2**ADDR_W
// PORTS
//  clk        in   1       rising-edge clock, single clock domain
//  reset      in   1       synchronous, active-high; sampled on rising clk
//  iss_valid  in   1       decode presents an instruction writing iss_dst
//  iss_dst    in   ADDR_W  destination register of issuing instruction
//  iss_src1   in   ADDR_W  first source register
//  iss_src2   in   ADDR_W  second source register
//  iss_stall  out  1       hazard: decode must hold; issue is accepted only when low
//  alu_valid  in   1       ALU writeback request
//  alu_ready  out  1       ALU request granted this cycle
//  alu_addr   in   ADDR_W  ALU destination register
//  alu_data   in   DATA_W  ALU result
//  mem_valid  in   1       load-unit writeback request
//  mem_ready  out  1       load request granted this cycle
//  mem_addr   in   ADDR_W  load destination register
//  mem_data   in   DATA_W  load data
//  rf_we      out  1       register-file write enable (to regfile we)
//  rf_a3      out  ADDR_W  register-file write address (to regfile a3)
//  rf_wd      out  DATA_W  register-file write data (to regfile wd)
//  busy       out  NREG    scoreboard; bit r = write to r outstanding
//  err_spur   out  1       sticky: a write was granted to a register that was not busy
// BEHAVIOUR
//  - Reset (sync): busy=0, rf_we=0, rf_a3=0, rf_wd=0, err_spur=0, rr_ptr=ALU.
//    Any in-flight grant is discarded; iss_stall/ready still evaluate combinationally from busy=0.
//  - busy[0] is hardwired to 0.
//  - iss_stall = iss_valid & (busy[iss_src1] | busy[iss_src2] | busy[iss_dst]) (combinational).
//  - Issue fires when iss_valid & !iss_stall & iss_dst!=0; busy[iss_dst] is set at that edge.
//  - Arbitration (combinational grant):
//    - only one source valid -> that source gets ready.
//    - both valid -> the source NOT named by rr_ptr wins.
//    - rr_ptr updates to the winner on every transfer.
//    - After reset, the first conflict therefore goes to MEM.
//  - Handshake: transfer = valid & ready. A requester holds valid/addr/data stable until ready.
//    ready never depends on the same requester's data; at most one ready is high per cycle.
//  - Write stage: on a transfer edge, rf_we<=1, rf_a3<=addr, rf_wd<=data; otherwise rf_we<=0.
//    Latency is 1 cycle from grant to rf_we. The register file commits at the following edge.
//  - Transfer with addr==0: accepted and dropped; rf_we stays 0 and busy is unaffected.
//  - busy[rf_a3] is cleared on the edge where rf_we=1, which is the same edge the register
//    file writes. An instruction issued after that edge reads new data. No forwarding path.
//  - Same edge with set busy[r] by issue and clear busy[r] by rf_we: set wins.
//    This cannot occur legally while busy[r]=1 (WAW stall), but the rule is fixed.
//  - Transfer to a register with busy=0: the write still proceeds; err_spur<=1 (sticky until reset).
//  - Throughput: one register-file write per cycle; a continuously valid source gets at least
//    every other grant under contention.
// TESTING
//  1. Reset, then issue dst=5 -> busy[5]=1 next cycle. Issue src1=5 -> iss_stall=1.
//     ALU valid addr=5 data=0xDEADBEEF -> alu_ready=1; next cycle rf_we=1 a3=5 wd=0xDEADBEEF;
//     after that edge busy[5]=0 and iss_stall=0.
//  2. Issue dst=3 and dst=4. ALU(3,0x11) and MEM(4,0x22) valid in the same cycle ->
//     mem_ready=1 first, rf_wd=0x22; next cycle alu_ready=1, rf_wd=0x11; both busy bits clear.
//  3. Both sources valid for 6 cycles (regs pre-busied) -> grants alternate MEM,ALU,MEM,...;
//     rf_we high 6 consecutive cycles.
//  4. ALU valid addr=0 data=0xFFFFFFFF -> alu_ready=1, rf_we stays 0, busy unchanged.
//     MEM write to non-busy reg 9 -> rf_we=1 a3=9, err_spur=1 and held.
//  5. Issue dst=7, then assert reset during the cycle MEM is granted addr 7 -> next cycle
//     rf_we=0, busy=0, err_spur=0.
//  6. busy[6]=1, issue with dst=6 (WAW) -> iss_stall=1 until the cycle after rf_we for reg 6.

Source files
------------

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for a single-write-port register file: round-robin ALU/MEM
// arbitration, one-cycle write stage, busy scoreboard and RAW/WAW decode stall.
module regfile_wb_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic [ADDR_W-1:0] iss_src1,
  input  logic [ADDR_W-1:0] iss_src2,
  output logic              iss_stall,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd,
  output logic [NREG-1:0]   busy,
  output logic              err_spur
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  src_e              rr_q, rr_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_a3_q, rf_a3_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
  logic              err_q, err_d;

  logic              alu_xfer;
  logic              mem_xfer;
  logic              xfer;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;
  logic              iss_fire;

  // Hazard check reads only the scoreboard, so a stalled decode never waits on itself.
  always_comb begin
    iss_stall = iss_valid & (busy_q[iss_src1] | busy_q[iss_src2] | busy_q[iss_dst]);
    iss_fire  = iss_valid & ~iss_stall & (iss_dst != '0);
  end

  // Under contention the source that did not win last time is granted.
  always_comb begin
    alu_ready = alu_valid & (~mem_valid | (rr_q == SRC_MEM));
    mem_ready = mem_valid & (~alu_valid | (rr_q == SRC_ALU));
    alu_xfer  = alu_valid & alu_ready;
    mem_xfer  = mem_valid & mem_ready;
    xfer      = alu_xfer | mem_xfer;
    xfer_addr = mem_xfer ? mem_addr : alu_addr;
    xfer_data = mem_xfer ? mem_data : alu_data;
  end

  always_comb begin
    rr_d    = rr_q;
    rf_we_d = 1'b0;
    rf_a3_d = rf_a3_q;
    rf_wd_d = rf_wd_q;
    err_d   = err_q;
    if (xfer) begin
      rr_d = mem_xfer ? SRC_MEM : SRC_ALU;
      // Writes to r0 are consumed here and never reach the register file.
      if (xfer_addr != '0) begin
        rf_we_d = 1'b1;
        rf_a3_d = xfer_addr;
        rf_wd_d = xfer_data;
        if (!busy_q[xfer_addr]) begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Per-register scoreboard: clear on commit, set on issue, set wins on a collision.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        always_comb busy_d[gi] = 1'b0;
      end else begin : g_reg
        always_comb begin
          busy_d[gi] = busy_q[gi];
          if (rf_we_q && (rf_a3_q == ADDR_W'(gi))) begin
            busy_d[gi] = 1'b0;
          end
          if (iss_fire && (iss_dst == ADDR_W'(gi))) begin
            busy_d[gi] = 1'b1;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q    <= SRC_ALU;
      busy_q  <= '0;
      rf_we_q <= 1'b0;
      rf_a3_q <= '0;
      rf_wd_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      rf_we_q <= rf_we_d;
      rf_a3_q <= rf_a3_d;
      rf_wd_q <= rf_wd_d;
      err_q   <= err_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_a3    = rf_a3_q;
  assign rf_wd    = rf_wd_q;
  assign busy     = busy_q;
  assign err_spur = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: hazard stalls, arbitration order, write stage,
// r0 drop, spurious-write flag and reset behaviour.
module tb_regfile_wb_sched;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_dst, iss_src1, iss_src2;
  logic              iss_stall;
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_a3;
  logic [DATA_W-1:0] rf_wd;
  logic [NREG-1:0]   busy;
  logic              err_spur;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .busy(busy), .err_spur(err_spur)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] dst);
    iss_valid = 1'b1; iss_dst = dst; iss_src1 = '0; iss_src2 = '0;
    step();
    iss_valid = 1'b0;
  endtask

  int alu_i, mem_i;
  logic [ADDR_W-1:0] exp_a3;

  initial begin
    reset = 1'b1; iss_valid = 1'b0; iss_dst = '0; iss_src1 = '0; iss_src2 = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    step(); step();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_we", rf_we, 0);
    check("rst_a3", rf_a3, 0);
    check("rst_wd", rf_wd, 0);
    check("rst_err", err_spur, 0);

    // Test 1: RAW stall cleared by ALU writeback
    $display("test1: RAW on r5 resolved by ALU write");
    issue(5);
    check("t1_busy5", busy, 32'h0000_0020);
    iss_valid = 1'b1; iss_src1 = 5; iss_dst = 1; settle();
    check("t1_stall", iss_stall, 1);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5; alu_data = 32'hDEAD_BEEF; settle();
    check("t1_alu_rdy", alu_ready, 1);
    check("t1_mem_rdy", mem_ready, 0);
    step(); alu_valid = 1'b0;
    check("t1_we", rf_we, 1);
    check("t1_a3", rf_a3, 5);
    check("t1_wd", rf_wd, 32'hDEAD_BEEF);
    check("t1_busy_hold", busy, 32'h0000_0020);
    step();
    check("t1_we_low", rf_we, 0);
    check("t1_busy_clr", busy, 0);
    iss_valid = 1'b1; iss_src1 = 5; iss_dst = 1; settle();
    check("t1_nostall", iss_stall, 0);
    iss_valid = 1'b0; iss_src1 = 0;

    // Test 2: simultaneous ALU/MEM; ALU won last, so MEM goes first
    $display("test2: ALU(3) and MEM(4) contend");
    issue(3); issue(4);
    check("t2_busy", busy, 32'h0000_0018);
    alu_valid = 1'b1; alu_addr = 3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 4; mem_data = 32'h22; settle();
    check("t2_mem_rdy", mem_ready, 1);
    check("t2_alu_wait", alu_ready, 0);
    step(); mem_valid = 1'b0;
    check("t2_wd_mem", rf_wd, 32'h22);
    check("t2_a3_mem", rf_a3, 4);
    settle();
    check("t2_alu_rdy", alu_ready, 1);
    step(); alu_valid = 1'b0;
    check("t2_wd_alu", rf_wd, 32'h11);
    check("t2_a3_alu", rf_a3, 3);
    check("t2_busy_mid", busy, 32'h0000_0008);
    step();
    check("t2_busy_clr", busy, 0);

    // Test 3: sustained contention alternates MEM, ALU, ...
    $display("test3: alternating grants over 6 cycles");
    for (int r = 10; r < 16; r++) issue(ADDR_W'(r));
    check("t3_busy", busy, 32'h0000_FC00);
    alu_i = 0; mem_i = 0;
    alu_valid = 1'b1; alu_addr = 10; alu_data = 32'hA0;
    mem_valid = 1'b1; mem_addr = 13; mem_data = 32'hB0;
    for (int k = 0; k < 6; k++) begin
      settle();
      check($sformatf("t3_mem_rdy%0d", k), mem_ready, ((k % 2) == 0) ? 1 : 0);
      exp_a3 = ((k % 2) == 0) ? ADDR_W'(13 + k / 2) : ADDR_W'(10 + k / 2);
      step();
      check($sformatf("t3_we%0d", k), rf_we, 1);
      check($sformatf("t3_a3_%0d", k), rf_a3, exp_a3);
      if ((k % 2) == 0) begin
        mem_i++;
        if (mem_i < 3) begin mem_addr = ADDR_W'(13 + mem_i); mem_data = 32'hB0 + mem_i; end
        else mem_valid = 1'b0;
      end else begin
        alu_i++;
        if (alu_i < 3) begin alu_addr = ADDR_W'(10 + alu_i); alu_data = 32'hA0 + alu_i; end
        else alu_valid = 1'b0;
      end
    end
    step();
    check("t3_busy_clr", busy, 0);
    check("t3_err", err_spur, 0);

    // Test 4: r0 drop and spurious write
    $display("test4: r0 write dropped, spurious write to r9");
    alu_valid = 1'b1; alu_addr = 0; alu_data = 32'hFFFF_FFFF; settle();
    check("t4_alu_rdy", alu_ready, 1);
    step(); alu_valid = 1'b0;
    check("t4_we0", rf_we, 0);
    check("t4_busy0", busy, 0);
    check("t4_err0", err_spur, 0);
    mem_valid = 1'b1; mem_addr = 9; mem_data = 32'h99; settle();
    check("t4_mem_rdy", mem_ready, 1);
    step(); mem_valid = 1'b0;
    check("t4_we9", rf_we, 1);
    check("t4_a3_9", rf_a3, 9);
    check("t4_err1", err_spur, 1);
    step(); step();
    check("t4_err_sticky", err_spur, 1);
    check("t4_busy", busy, 0);

    // Test 5: reset during a grant discards it
    $display("test5: reset during MEM grant to r7");
    issue(7);
    check("t5_busy7", busy, 32'h0000_0080);
    mem_valid = 1'b1; mem_addr = 7; mem_data = 32'h77; reset = 1'b1; settle();
    check("t5_mem_rdy", mem_ready, 1);
    step(); reset = 1'b0; mem_valid = 1'b0;
    check("t5_we", rf_we, 0);
    check("t5_busy", busy, 0);
    check("t5_err", err_spur, 0);

    // Test 6: WAW stall on r6; also confirms MEM wins first conflict after reset
    $display("test6: WAW on r6");
    issue(6);
    check("t6_busy6", busy, 32'h0000_0040);
    iss_valid = 1'b1; iss_dst = 6; iss_src1 = 0; iss_src2 = 0;
    alu_valid = 1'b1; alu_addr = 6; alu_data = 32'h66;
    mem_valid = 1'b1; mem_addr = 0; mem_data = 32'h0; settle();
    check("t6_stall0", iss_stall, 1);
    check("t6_mem_first", mem_ready, 1);
    step(); mem_valid = 1'b0;
    check("t6_we_r0", rf_we, 0);
    check("t6_stall1", iss_stall, 1);
    check("t6_alu_rdy", alu_ready, 1);
    step(); alu_valid = 1'b0;
    check("t6_we6", rf_we, 1);
    check("t6_a3_6", rf_a3, 6);
    check("t6_stall2", iss_stall, 1);
    step();
    check("t6_busy_clr", busy, 0);
    check("t6_stall_rel", iss_stall, 0);
    step(); iss_valid = 1'b0;
    check("t6_reissue", busy, 32'h0000_0040);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
